digit_scan: RTL and testbench

Parametrised multiplexed-display scanner for the seven-segment path. It walks a one-hot digit select across `DIGITS` positions at a prescaled rate and presents the 4-bit value and decimal point of the active digit to the segment decoder. Each frame uses a tear-free shadow copy of the digit values. A blanking guard at the start of every slot suppresses ghosting. Per-digit blank masking, selectable anode polarity and slot/frame strobes are provided; optional brightness dimming is available at compile time.

---
 rtl/digit_scan.sv | 141 ++++++++++++++
 tb/tb_digit_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan.sv
// digit_scan -- multiplexed seven-segment digit scanner.
//
// Walks a one-hot digit select across DIGITS positions, MSB digit first, one
// slot every 2^PRESC_W clocks. Digit values and decimal points are captured
// into a shadow copy once per frame so a frame never mixes old and new data.
// The first GUARD clocks of every slot keep the anodes dark to avoid ghosting
// while the segment lines settle on the new digit.
//
// Compile-time option: define DIGIT_SCAN_DIM_EN to add the `bright` input,
// which additionally limits the lit window of each slot to p < bright.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   digits_in  in   4*DIGITS, digit i at [4i+3:4i]
//   dp_in      in   DIGITS, decimal point per digit
//   blank_in   in   DIGITS, 1 forces digit i dark (sampled live)
//   bright     in   PRESC_W, dimming threshold (DIGIT_SCAN_DIM_EN only)
//   anode      out  DIGITS, one-hot digit enable, polarity per ANODE_POL
//   bcd        out  4, value of the active digit
//   dp         out  1, decimal point of the active digit
//   idx        out  $clog2(DIGITS), current slot index
//   en         out  1, strobe on the last clock of each slot
//   frame      out  1, strobe on the last clock of each frame
module digit_scan #(
  parameter int DIGITS    = 4,
  parameter int PRESC_W   = 5,
  parameter int GUARD     = 2,
  parameter int ANODE_POL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4*DIGITS-1:0]        digits_in,
  input  logic [DIGITS-1:0]          dp_in,
  input  logic [DIGITS-1:0]          blank_in,
`ifdef DIGIT_SCAN_DIM_EN
  input  logic [PRESC_W-1:0]         bright,
`endif
  output logic [DIGITS-1:0]          anode,
  output logic [3:0]                 bcd,
  output logic                       dp,
  output logic [$clog2(DIGITS)-1:0]  idx,
  output logic                       en,
  output logic                       frame
);

  localparam int                  IDX_W     = $clog2(DIGITS);
  localparam logic [PRESC_W-1:0]  P_MAX     = {PRESC_W{1'b1}};
  localparam logic [PRESC_W-1:0]  GUARD_P   = PRESC_W'(GUARD);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]   ANODE_OFF = (ANODE_POL != 0) ? {DIGITS{1'b0}}
                                                               : {DIGITS{1'b1}};

  // Scan state
  logic [PRESC_W-1:0] p_q, p_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         sh_val_q [DIGITS];
  logic [3:0]         sh_val_d [DIGITS];
  logic [DIGITS-1:0]  sh_dp_q, sh_dp_d;
  logic               frame_edge;

  // Registered outputs
  logic [DIGITS-1:0]  anode_q, anode_d;
  logic [3:0]         bcd_q, bcd_d;
  logic               dp_q, dp_d;
  logic               en_q, en_d;
  logic               frame_q, frame_d;

  logic               active;
  logic [DIGITS-1:0]  anode_hot;

  // Prescaler wraps naturally; the slot index steps down when it wraps.
  always_comb begin
    p_d   = p_q + 1'b1;
    idx_d = idx_q;
    if (p_q == P_MAX) begin
      idx_d = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
    end
  end

  // Last clock of the last slot: capture the next frame's digits.
  assign frame_edge = (p_q == P_MAX) && (idx_q == '0);
  assign sh_dp_d    = frame_edge ? dp_in : sh_dp_q;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_shadow
    assign sh_val_d[gi] = frame_edge ? digits_in[4*gi +: 4] : sh_val_q[gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_val_q[gi] <= 4'h0;
      end else begin
        sh_val_q[gi] <= sh_val_d[gi];
      end
    end
  end

  // Outputs are computed from the post-edge state so they line up with idx.
  always_comb begin
    active = (p_d >= GUARD_P) && !blank_in[idx_d];
`ifdef DIGIT_SCAN_DIM_EN
    active = active && (p_d < bright);
`endif
    anode_hot        = '0;
    anode_hot[idx_d] = active;
    anode_d          = (ANODE_POL != 0) ? anode_hot : ~anode_hot;
    bcd_d            = sh_val_d[idx_d];
    dp_d             = sh_dp_d[idx_d];
    en_d             = (p_d == P_MAX);
    frame_d          = en_d && (idx_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      idx_q   <= LAST_IDX;
      sh_dp_q <= '0;
      anode_q <= ANODE_OFF;
      bcd_q   <= 4'h0;
      dp_q    <= 1'b0;
      en_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      idx_q   <= idx_d;
      sh_dp_q <= sh_dp_d;
      anode_q <= anode_d;
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      frame_q <= frame_d;
    end
  end

  assign anode = anode_q;
  assign bcd   = bcd_q;
  assign dp    = dp_q;
  assign idx   = idx_q;
  assign en    = en_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan -- scoreboard bench for digit_scan (DIGITS=4, PRESC_W=3,
// GUARD=1). Expected samples are queued keyed by (reset epoch, cycle since
// reset release; -1 means while reset is held) and a monitor compares them on
// the falling clock edge. A second instance checks the active-low anode build.
module tb_digit_scan;

  localparam int M_AN = 5, M_B = 4, M_D = 3, M_IX = 2, M_E = 1, M_F = 0;
  localparam logic [5:0] ALL = 6'b111111;

  typedef struct {
    int         ep;
    int         cy;
    string      nm;
    logic [5:0] m;
    logic [3:0] an;
    logic [3:0] b;
    logic       d;
    logic [1:0] ix;
    logic       e;
    logic       f;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  anode, anode_n;
  logic [3:0]  bcd, bcd_n;
  logic        dp, dp_n;
  logic [1:0]  idx, idx_n;
  logic        en, en_n;
  logic        frame, frame_n;

  exp_t q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   ep_mon   = -1;
  int   cyc_mon  = -1;
  logic in_rst   = 1'b0;
  logic prev_en  = 1'b0;
  logic prev_fr  = 1'b0;

  digit_scan #(.DIGITS(4), .PRESC_W(3), .GUARD(1), .ANODE_POL(1)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .anode(anode), .bcd(bcd), .dp(dp), .idx(idx),
    .en(en), .frame(frame)
  );

  digit_scan #(.DIGITS(4), .PRESC_W(3), .GUARD(1), .ANODE_POL(0)) dut_n (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .anode(anode_n), .bcd(bcd_n), .dp(dp_n), .idx(idx_n),
    .en(en_n), .frame(frame_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ex(int ep, int cy, string nm, logic [5:0] m,
                             logic [3:0] an, logic [3:0] b, logic d,
                             logic [1:0] ix, logic e, logic f);
    exp_t t;
    t.ep = ep; t.cy = cy; t.nm = nm; t.m = m;
    t.an = an; t.b = b; t.d = d; t.ix = ix; t.e = e; t.f = f;
    q.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    chk_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s epoch=%0d cyc=%0d: got %b, expected %b",
               nm, ep_mon, cyc_mon, act, req);
    end
  endtask

  task automatic check_entry(input exp_t t);
    if (t.m[M_AN]) begin
      chk({t.nm, "_anode"}, anode, t.an);
      chk({t.nm, "_anode_lo"}, anode_n, ~t.an);
    end
    if (t.m[M_B])  chk({t.nm, "_bcd"}, bcd, t.b);
    if (t.m[M_D])  chk({t.nm, "_dp"}, {3'b000, dp}, {3'b000, t.d});
    if (t.m[M_IX]) chk({t.nm, "_idx"}, {2'b00, idx}, {2'b00, t.ix});
    if (t.m[M_E])  chk({t.nm, "_en"}, {3'b000, en}, {3'b000, t.e});
    if (t.m[M_F])  chk({t.nm, "_frame"}, {3'b000, frame}, {3'b000, t.f});
  endtask

  // Monitor: tracks epoch/cycle and pops every expectation due now.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (!in_rst) begin
          ep_mon++;
          in_rst = 1'b1;
        end
        cyc_mon = -1;
        prev_en = 1'b0;
        prev_fr = 1'b0;
      end else begin
        if (in_rst) begin
          in_rst  = 1'b0;
          cyc_mon = 0;
        end else begin
          cyc_mon++;
        end
        chk("strobe_gap", {2'b00, en & prev_en, frame & prev_fr}, 4'b0000);
        prev_en = en;
        prev_fr = frame;
      end
      for (int i = 0; i < q.size(); ) begin
        if (q[i].ep == ep_mon && q[i].cy == cyc_mon) begin
          check_entry(q[i]);
          q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Stimulus
  initial begin
    rst       = 1'b1;
    digits_in = 16'h4321;
    dp_in     = 4'b1010;
    blank_in  = 4'b0000;

    // Epoch 0: power-on run through three frames.
    ex(0, -1, "rst_vals", ALL, 4'b0000, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(0, 0, "guard_c0", 6'b110111, 4'b0000, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      ex(0, c, "slot3_on", 6'b110111, 4'b1000, 4'h0, 1'b0, 2'd3, (c == 7), 1'b0);
    end
    ex(0, 8,  "guard_c8", 6'b110111, 4'b0000, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    ex(0, 9,  "slot2_on", 6'b110111, 4'b0100, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    ex(0, 17, "slot1_on", 6'b110111, 4'b0010, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0);
    ex(0, 25, "slot0_on", 6'b110111, 4'b0001, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    ex(0, 30, "f1_c30",   ALL, 4'b0001, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    ex(0, 31, "f1_end",   ALL, 4'b0001, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    ex(0, 32, "f2_d3_g",  ALL, 4'b0000, 4'h4, 1'b1, 2'd3, 1'b0, 1'b0);
    ex(0, 33, "f2_d3",    ALL, 4'b1000, 4'h4, 1'b1, 2'd3, 1'b0, 1'b0);
    ex(0, 39, "f2_slotend", ALL, 4'b1000, 4'h4, 1'b1, 2'd3, 1'b1, 1'b0);
    ex(0, 41, "f2_d2",    ALL, 4'b0100, 4'h3, 1'b0, 2'd2, 1'b0, 1'b0);
    ex(0, 48, "f2_d1",    6'b111100, 4'b0000, 4'h2, 1'b1, 2'd1, 1'b0, 1'b0);
    ex(0, 56, "f2_d0",    6'b111100, 4'b0000, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
    ex(0, 63, "f2_end",   ALL, 4'b0001, 4'h1, 1'b0, 2'd0, 1'b1, 1'b1);
    ex(0, 64, "f3_new",   ALL, 4'b0000, 4'h9, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(0, 65, "f3_d3",    6'b110100, 4'b1000, 4'h9, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(0, 73, "f3_d2",    6'b100100, 4'b0100, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    ex(0, 81, "blanked",  6'b111100, 4'b0000, 4'h9, 1'b0, 2'd1, 1'b0, 1'b0);
    ex(0, 83, "blanked2", 6'b100100, 4'b0000, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0);
    ex(0, 84, "blank_lat", 6'b100100, 4'b0000, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0);
    ex(0, 85, "unblank",  6'b100100, 4'b0010, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0);
    ex(0, 89, "f3_d0",    6'b100100, 4'b0001, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    ex(0, 95, "f3_end",   6'b000111, 4'b0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    ex(0, 99, "pre_rst",  6'b110100, 4'b1000, 4'h9, 1'b0, 2'd3, 1'b0, 1'b0);
    // Epoch 1: reset pulsed mid-slot while showing 9s.
    ex(1, -1, "async_rst1", ALL, 4'b0000, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(1, 0,  "e1_c0",    ALL, 4'b0000, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(1, 1,  "shadow_clr", ALL, 4'b1000, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(1, 7,  "e1_c7",    6'b100111, 4'b1000, 4'h0, 1'b0, 2'd3, 1'b1, 1'b0);
    ex(1, 8,  "e1_c8",    6'b100110, 4'b0000, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    ex(1, 9,  "e1_c9",    6'b100100, 4'b0100, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    ex(1, 12, "e1_c12",   6'b100100, 4'b0100, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    // Epoch 2: reset pulsed at cycle 13 of epoch 1.
    ex(2, -1, "async_rst2", ALL, 4'b0000, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(2, 0,  "e2_c0",    6'b100100, 4'b0000, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(2, 1,  "e2_c1",    6'b100100, 4'b1000, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(2, 7,  "e2_c7",    6'b000010, 4'b0000, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    ex(2, 8,  "e2_c8",    6'b100100, 4'b0000, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    ex(2, 9,  "e2_c9",    6'b100100, 4'b0100, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0);
    ex(2, 31, "e2_f1end", ALL, 4'b0001, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    ex(2, 32, "e2_f2",    ALL, 4'b0000, 4'h9, 1'b0, 2'd3, 1'b0, 1'b0);
    ex(2, 33, "e2_f2_on", 6'b110000, 4'b1000, 4'h9, 1'b0, 2'd3, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;                 // now in cycle 0 of epoch 0
    advance(40);                   // cycle 40: change data mid-frame
    digits_in = 16'h9999;
    dp_in     = 4'b0000;
    advance(24);                   // cycle 64: blank digit 1
    blank_in  = 4'b0010;
    advance(20);                   // cycle 84: unblank
    blank_in  = 4'b0000;
    advance(16);                   // cycle 100: asynchronous reset mid-slot
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;                 // epoch 1, cycle 0
    advance(13);                   // cycle 13: reset again
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;                 // epoch 2, cycle 0
    advance(40);
    @(negedge clk);
    #1;
    foreach (q[i]) begin
      chk_cnt++;
      $display("FAIL missed_%s: epoch %0d cycle %0d was never sampled",
               q[i].nm, q[i].ep, q[i].cy);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
